// File: rtl/elevator_if.sv
// Car-panel bundle for elevator_ctrl: call buttons in, lamps and position indicators out.
// master = the controller, slave = the panel/environment driving the buttons.
interface elevator_if #(
  parameter int FLOORS = 4
);
  localparam int FW = $clog2(FLOORS);

  logic [FLOORS-1:0] call_btn;
  logic [FLOORS-1:0] call_led;
  logic [FLOORS-1:0] floor_onehot;
  logic [FW-1:0]     floor_idx;
  logic              door_open;
  logic              moving;
  logic              dir_up;

  modport master (
    input  call_btn,
    output call_led, floor_onehot, floor_idx, door_open, moving, dir_up
  );

  modport slave (
    output call_btn,
    input  call_led, floor_onehot, floor_idx, door_open, moving, dir_up
  );
endinterface

// File: rtl/elevator_ctrl.sv
// N-floor elevator car controller: call latching, sweep direction choice, timed travel and door.
// Optional ELEVATOR_CTRL_REOPEN_EN: own-floor press while the door is open restarts the dwell.
module elevator_ctrl #(
  parameter int FLOORS    = 4,
  parameter int MOVE_TIME = 5,
  parameter int DOOR_TIME = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  elevator_if.master  bus
);
  localparam int FW = $clog2(FLOORS);
  localparam int MW = (MOVE_TIME > 1) ? $clog2(MOVE_TIME) : 1;
  localparam int DW = (DOOR_TIME > 1) ? $clog2(DOOR_TIME) : 1;
  localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_TIME - 1);
  localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_TIME - 1);

  typedef enum logic [1:0] {S_IDLE, S_MOVING, S_DOOR_OPEN} state_t;

  state_t            state_q, state_d;
  logic [FW-1:0]     floor_q, floor_d, step_floor;
  logic [FLOORS-1:0] led_q, led_d, onehot_q;
  logic [MW-1:0]     move_cnt_q, move_cnt_d;
  logic [DW-1:0]     door_cnt_q, door_cnt_d;
  logic              dir_q, dir_d;
  logic              moving_q, door_open_q;
  logic              own_press, reopen, any_above, any_below;

  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (led_q[i] && (i > int'(floor_q))) any_above = 1'b1;
      if (led_q[i] && (i < int'(floor_q))) any_below = 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    led_d      = led_q | bus.call_btn;
    dir_d      = dir_q;
    move_cnt_d = move_cnt_q;
    door_cnt_d = door_cnt_q;
    own_press  = bus.call_btn[floor_q];
    step_floor = dir_q ? floor_q + FW'(1) : floor_q - FW'(1);
    reopen     = 1'b0;
`ifdef ELEVATOR_CTRL_REOPEN_EN
    reopen     = own_press;
`endif

    unique case (state_q)
      S_IDLE: begin
        // A press at the floor the car stands on is served by the door, never latched.
        led_d[floor_q] = 1'b0;
        if (own_press) begin
          state_d    = S_DOOR_OPEN;
          door_cnt_d = '0;
        end else if (led_q != '0) begin
          state_d    = S_MOVING;
          move_cnt_d = '0;
          dir_d      = any_above && (dir_q || !any_below);
        end
      end

      S_MOVING: begin
        if (move_cnt_q == MOVE_LAST) begin
          floor_d    = step_floor;
          move_cnt_d = '0;
          if (led_q[step_floor] || bus.call_btn[step_floor]) begin
            state_d           = S_DOOR_OPEN;
            door_cnt_d        = '0;
            led_d[step_floor] = 1'b0;
          end
        end else begin
          move_cnt_d = move_cnt_q + MW'(1);
        end
      end

      S_DOOR_OPEN: begin
        led_d[floor_q] = 1'b0;
        // The press cycle counts as dwell cycle 0, so the next cycle is count 1.
        if (reopen && (DOOR_TIME > 1)) begin
          door_cnt_d = DW'(1);
        end else if (door_cnt_q == DOOR_LAST) begin
          state_d = S_IDLE;
        end else begin
          door_cnt_d = door_cnt_q + DW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      floor_q     <= '0;
      onehot_q    <= FLOORS'(1);
      led_q       <= '0;
      dir_q       <= 1'b1;
      move_cnt_q  <= '0;
      door_cnt_q  <= '0;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      floor_q     <= floor_d;
      onehot_q    <= FLOORS'(1) << floor_d;
      led_q       <= led_d;
      dir_q       <= dir_d;
      move_cnt_q  <= move_cnt_d;
      door_cnt_q  <= door_cnt_d;
      moving_q    <= (state_d == S_MOVING);
      door_open_q <= (state_d == S_DOOR_OPEN);
    end
  end

  assign bus.call_led     = led_q;
  assign bus.floor_onehot = onehot_q;
  assign bus.floor_idx    = floor_q;
  assign bus.door_open    = door_open_q;
  assign bus.moving       = moving_q;
  assign bus.dir_up       = dir_q;
endmodule

// File: doc/elevator_ctrl.md
# elevator_ctrl

Parametrised car controller for an N-floor elevator: latches hall/car call buttons, chooses travel direction with a sweep policy, steps the car one floor per `MOVE_TIME` cycles, and holds the door open `DOOR_TIME` cycles at each served floor. It replaces the fixed three-floor movement block. It is the single owner of car position, door and call-lamp state, and drives the floor indicators and lamps directly.

## Interface
Parameters:
- `FLOORS`, 4: number of floors, ≥2; floor 0 is the bottom.
- `MOVE_TIME`, 5: clock cycles to travel one floor, ≥1.
- `DOOR_TIME`, 2: clock cycles the door stays open, ≥1.
- `FW` (derived), `$clog2(FLOORS)`: floor index width.

Ports:
- `clk`  in  1  single clock, all state changes on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `call_btn`  in  FLOORS  one bit per floor, level-sampled every cycle.
- `call_led`  out  FLOORS  pending-request register, one lamp per floor.
- `floor_onehot`  out  FLOORS  one-hot current floor.
- `floor_idx`  out  FW  binary current floor.
- `door_open`  out  1  high in DOOR_OPEN state.
- `moving`  out  1  high in MOVING state.
- `dir_up`  out  1  current or last sweep direction; 1 = up.

## Operation
- States: IDLE (stopped, door closed), MOVING, DOOR_OPEN. All outputs are registered.
- Reset (`rst_n`=0 at an edge, any state): IDLE, `floor_idx`=0, `floor_onehot`=1, `call_led`=0, `door_open`=0, `moving`=0, `dir_up`=1. Both counters are cleared. Reset mid-move or mid-door abandons the operation.
- Latching: `call_led[i]` is set on the edge after `call_btn[i]`=1. Exception: bit i equals the current floor and the state is IDLE or DOOR_OPEN; that press is served and never latched. Bits clear only when their floor is served.
- IDLE, own-floor press: next edge goes to DOOR_OPEN.
- IDLE, no own-floor press, `call_led`≠0: next edge goes to MOVING.
  - Direction is up if any pending floor is above, and either `dir_up`=1 or no pending floor is below.
  - Otherwise direction is down. `dir_up` updates on the same edge.
- MOVING: the move counter counts 0..`MOVE_TIME`-1. On the edge where it reaches `MOVE_TIME`-1:
  - The floor steps ±1.
  - If (`call_led` | `call_btn`) has the new floor's bit set: go to DOOR_OPEN and clear that bit on the same edge.
  - Otherwise stay in MOVING with the counter reset to 0.
- The car never steps past floor 0 or `FLOORS`-1. Direction is only chosen toward a pending floor, so arrival at an end floor always serves it.
- DOOR_OPEN: the door counter counts 0..`DOOR_TIME`-1. On its last cycle, next state is IDLE and `door_open` falls. IDLE re-arbitrates on the following cycle.
- Simultaneous presses: all are latched in one cycle. Service order is arrival order along the sweep.

## Timing
- Button-to-lamp latency: 1 cycle.
- IDLE to MOVING: 1 cycle after `call_led` becomes nonzero. Total from button press: 2 cycles.
- One floor of travel: exactly `MOVE_TIME` cycles with `moving`=1.
- Door dwell: exactly `DOOR_TIME` cycles with `door_open`=1.
- `moving` and `door_open` are never both 1. Leaving DOOR_OPEN always passes through at least one IDLE cycle.
- Own-floor press in IDLE: `door_open`=1 on the next edge.

## Configuration
- `ELEVATOR_CTRL_REOPEN_EN` defined: an own-floor `call_btn` press during DOOR_OPEN resets the door counter to 0. This extends the dwell to a full `DOOR_TIME` counted from the press.
- Not defined: that press is discarded and the dwell ends on schedule. The press is still not latched.

## Test plan
- Reset, FLOORS=4, MOVE_TIME=5, DOOR_TIME=2; pulse `call_btn`=4'b1000 one cycle.
  - `call_led`=1000 next cycle; `moving` high 15 cycles.
  - Then `floor_idx`=3, `door_open` high 2 cycles, `call_led`=0.
- At floor 0 in IDLE, press `call_btn[0]` → `door_open`=1 next edge for 2 cycles; `call_led` stays 0.
- Car moving up from 0 with floor 3 pending; press floor 1 during the first step → car stops at 1 (door 2 cycles), then continues to 3.
- Car at 2, `dir_up`=1, floors 0 and 3 pending at once → serves 3 first, then 0; `dir_up` ends 0.
- Assert `rst_n`=0 mid-move between floors 1 and 2 → next edge: floor 0, all lamps off, `moving`=0.
- DOOR_OPEN at floor 1; own-floor press on its 2nd cycle.
  - With `ELEVATOR_CTRL_REOPEN_EN`: dwell totals 3 cycles.
  - Without: dwell totals 2 cycles.
